// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcode, format-index and funct3 constants
package rv32i_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Bit positions inside the one-hot instruction-class vector
  localparam int FMT_R      = 8;
  localparam int FMT_IALU   = 7;
  localparam int FMT_LOAD   = 6;
  localparam int FMT_STORE  = 5;
  localparam int FMT_BRANCH = 4;
  localparam int FMT_JAL    = 3;
  localparam int FMT_JALR   = 2;
  localparam int FMT_LUI    = 1;
  localparam int FMT_AUIPC  = 0;

  // Load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Branch conditions
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU / jump funct3 values that need special field handling
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // Shift-immediate forms carry a 5-bit shamt plus bit 30 instead of imm[11:0]
  function automatic logic is_shift_imm(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// rtl/rv32i_sync_fifo.sv - synchronous word FIFO with flush
module rv32i_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I field encoder feeding instruction-memory writes
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8:0]                     fmt,
  input  logic [4:0]                     rd,
  input  logic [4:0]                     rs1,
  input  logic [4:0]                     rs2,
  input  logic [2:0]                     funct3,
  input  logic                           funct7b5,
  input  logic [31:0]                    imm,
  output logic                           imem_we,
  output logic [31:0]                    imem_addr,
  output logic [31:0]                    imem_wdata,
  input  logic                           imem_ready,
  output logic [$clog2(MEM_WORDS):0]     words_written,
  output logic                           full,
  output logic                           err_illegal
);

  localparam int CW = $clog2(MEM_WORDS) + 1;
  localparam int FW = $clog2(DEPTH) + 1;

  logic [31:0]   enc_word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   fifo_rdata;
  logic [FW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW:0]   committed;
  logic          room;

  // Words already written plus words still queued must stay below capacity
  assign committed = {1'b0, words_written} + (CW + 1)'(fifo_count);
  assign room      = (committed < (CW + 1)'(MEM_WORDS));
  assign full      = (words_written == CW'(MEM_WORDS));
  assign in_ready  = !rst && !fifo_full && !full && !clear && room;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = imem_we && imem_ready && !clear;

  assign imem_we    = !fifo_empty;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_rdata;

  // Assemble the instruction word from the fields for the selected class
  always_comb begin
    enc_word = 32'h0;
    if (fmt[FMT_R]) begin
      enc_word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
    end else if (fmt[FMT_IALU]) begin
      if (is_shift_imm(funct3))
        enc_word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_IALU};
      else
        enc_word = {imm[11:0], rs1, funct3, rd, OP_IALU};
    end else if (fmt[FMT_LOAD]) begin
      enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
    end else if (fmt[FMT_STORE]) begin
      enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
    end else if (fmt[FMT_BRANCH]) begin
      enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
    end else if (fmt[FMT_JAL]) begin
      enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    end else if (fmt[FMT_JALR]) begin
      enc_word = {imm[11:0], rs1, funct3, rd, OP_JALR};
    end else if (fmt[FMT_LUI]) begin
      enc_word = {imm[31:12], rd, OP_LUI};
    end else if (fmt[FMT_AUIPC]) begin
      enc_word = {imm[31:12], rd, OP_AUIPC};
    end
  end

  // Reject malformed class vectors and reserved funct3/funct7 combinations
  always_comb begin
    legal = $onehot(fmt);
    if (fmt[FMT_LOAD] && !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
      legal = 1'b0;
    if (fmt[FMT_STORE] && !(funct3 inside {F3_SB, F3_SH, F3_SW}))
      legal = 1'b0;
    if (fmt[FMT_BRANCH] && !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU}))
      legal = 1'b0;
    if (fmt[FMT_JALR] && (funct3 != F3_JALR))
      legal = 1'b0;
    if (fmt[FMT_IALU] && (funct3 == F3_SLL) && funct7b5)
      legal = 1'b0;
    if (fmt[FMT_R] && funct7b5 && !(funct3 inside {F3_ADD_SUB, F3_SR}))
      legal = 1'b0;
  end

  // Write address, completed-word count and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr     <= BASE_ADDR;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else if (clear) begin
      imem_addr     <= BASE_ADDR;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else begin
      if (pop) begin
        imem_addr     <= imem_addr + 32'd4;
        words_written <= words_written + CW'(1);
      end
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end

  rv32i_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - randomized model-checked bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          MEM_WORDS = 20;
  localparam int          CW        = $clog2(MEM_WORDS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [8:0]    fmt = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7b5 = 1'b0;
  logic [31:0]   imm = '0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready = 1'b1;
  logic [CW-1:0] words_written;
  logic          full;
  logic          err_illegal;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  rv32i_instr_encoder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fmt           (fmt),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .imm           (imm),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .imem_ready    (imem_ready),
    .words_written (words_written),
    .full          (full),
    .err_illegal   (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: opcode per class bit, class 0 = AUIPC ... class 8 = R
  function automatic int cls_of(input logic [8:0] f);
    int k = -1;
    for (int i = 0; i < 9; i++) if (f[i]) k = i;
    return k;
  endfunction

  function automatic int ones_of(input logic [8:0] f);
    int n = 0;
    for (int i = 0; i < 9; i++) n += int'(f[i]);
    return n;
  endfunction

  function automatic bit ref_legal(input logic [8:0] f, input int f3, input bit f7);
    int k;
    if (ones_of(f) != 1) return 0;
    k = cls_of(f);
    case (k)
      6: return !(f3 == 3 || f3 == 6 || f3 == 7);
      5: return f3 <= 2;
      4: return !(f3 == 2 || f3 == 3);
      2: return f3 == 0;
      7: return !(f3 == 1 && f7);
      8: return !(f7 && f3 != 0 && f3 != 5);
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [8:0] f, input int d, input int s1,
                                          input int s2, input int f3, input bit f7,
                                          input logic [31:0] im);
    int unsigned opc [9] = '{32'h17, 32'h37, 32'h67, 32'h6F, 32'h63, 32'h23, 32'h03, 32'h13, 32'h33};
    int unsigned w, u;
    int k;
    k = cls_of(f);
    u = im;
    w = opc[k];
    case (k)
      8: w = w | (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (int'(f7) << 30);
      7: if (f3 == 1 || f3 == 5)
           w = w | (d << 7) | (f3 << 12) | (s1 << 15) | ((u % 32) << 20) | (int'(f7) << 30);
         else
           w = w | (d << 7) | (f3 << 12) | (s1 << 15) | ((u % 4096) << 20);
      6, 2: w = w | (d << 7) | (f3 << 12) | (s1 << 15) | ((u % 4096) << 20);
      5: w = w | ((u % 32) << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (((u / 32) % 128) << 25);
      4: w = w | (((u / 2048) % 2) << 7) | (((u / 2) % 16) << 8) | (f3 << 12) | (s1 << 15)
               | (s2 << 20) | (((u / 32) % 64) << 25) | (((u / 4096) % 2) << 31);
      3: w = w | (d << 7) | (((u / 4096) % 256) << 12) | (((u / 2048) % 2) << 20)
               | (((u / 2) % 1024) << 21) | (((u / 1048576) % 2) << 31);
      default: w = w | (d << 7) | ((u / 4096) * 4096);
    endcase
    return w;
  endfunction

  // Model state: queued words, next address, written count, sticky error
  logic [31:0] mq[$];
  logic [31:0] m_addr = BASE_ADDR;
  int          m_cnt = 0;
  bit          m_err = 1'b0;

  function automatic bit m_ready();
    return !rst && !clear && (mq.size() < DEPTH) && (m_cnt + mq.size() < MEM_WORDS);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_addr = BASE_ADDR;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else if (clear) begin
      mq.delete();
      m_addr = BASE_ADDR;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      bit acc, wr;
      acc = in_valid && m_ready();
      wr  = (mq.size() > 0) && imem_ready;
      if (wr) begin
        void'(mq.pop_front());
        m_addr = m_addr + 4;
        m_cnt++;
      end
      if (acc) begin
        if (ref_legal(fmt, int'(funct3), funct7b5))
          mq.push_back(ref_enc(fmt, int'(rd), int'(rs1), int'(rs2), int'(funct3), funct7b5, imm));
        else
          m_err = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("imem_we", 32'(imem_we), 32'(mq.size() > 0));
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, (mq.size() > 0) ? mq[0] : 32'h0);
      chk("words_written", 32'(words_written), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == MEM_WORDS));
      chk("err_illegal", 32'(err_illegal), 32'(m_err));
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [8:0] f, input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic [2:0] f3, input logic f7, input logic [31:0] im);
    in_valid = v; fmt = f; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7b5 = f7; imm = im;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_we"}, 32'(imem_we), 32'h0);
    chk({tag, "_addr"}, imem_addr, BASE_ADDR);
    chk({tag, "_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_ww"}, 32'(words_written), 32'h0);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_err"}, 32'(err_illegal), 32'h0);
  endtask

  initial begin
    // Pin the reference model to hand-assembled words
    chk("pin_addi", ref_enc(9'h080, 1, 0, 0, 0, 0, 32'd5), 32'h0050_0093);
    chk("pin_add", ref_enc(9'h100, 3, 1, 2, 0, 0, 32'd0), 32'h0020_81B3);
    chk("pin_sub", ref_enc(9'h100, 3, 1, 2, 0, 1, 32'd0), 32'h4020_81B3);
    chk("pin_sw", ref_enc(9'h020, 0, 1, 2, 2, 0, 32'd8), 32'h0020_A423);
    chk("pin_beq", ref_enc(9'h010, 0, 1, 2, 0, 0, 32'd8), 32'h0020_8463);
    chk("pin_lui", ref_enc(9'h002, 5, 0, 0, 0, 0, 32'h1234_5000), 32'h1234_52B7);
    chk("pin_jal", ref_enc(9'h008, 1, 0, 0, 0, 0, 32'h0000_0800), 32'h0010_00EF);
    chk("pin_illegal", 32'(ref_legal(9'h004, 1, 0)), 32'h0);

    repeat (3) sample();
    reset_literals("reset");
    rst = 1'b0;
    cmp_en = 1'b1;
    sample();
    chk("ready_after_reset", 32'(in_ready), 32'h1);

    // addi x1,x0,5 -> written next cycle
    req(1, 9'h080, 1, 0, 0, 0, 0, 32'd5);
    sample();
    req(0, 9'h080, 1, 0, 0, 0, 0, 32'd5);
    chk("addi_we", 32'(imem_we), 32'h1);
    chk("addi_addr", imem_addr, 32'h0);
    chk("addi_wdata", imem_wdata, 32'h0050_0093);

    // add then sub back-to-back, then sw, beq, lui
    req(1, 9'h100, 3, 1, 2, 0, 0, 32'd0); sample();
    req(1, 9'h100, 3, 1, 2, 0, 1, 32'd0); sample();
    req(1, 9'h020, 0, 1, 2, 2, 0, 32'd8); sample();
    req(1, 9'h010, 0, 1, 2, 0, 0, 32'd8); sample();
    req(1, 9'h002, 5, 0, 0, 0, 0, 32'h1234_5000); sample();
    req(0, 9'h0, 0, 0, 0, 0, 0, 32'd0);
    repeat (3) sample();
    chk("seq_ww", 32'(words_written), 32'd6);
    chk("seq_addr", imem_addr, 32'h18);

    // Memory stalled: only DEPTH requests get in, head word holds
    imem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req(1, 9'h080, 1, 0, 0, 0, 0, 32'(i));
      sample();
    end
    req(0, 9'h0, 0, 0, 0, 0, 0, 32'd0);
    chk("stall_ready", 32'(in_ready), 32'h0);
    chk("stall_head", imem_wdata, 32'h0000_0093);
    repeat (4) sample();
    chk("stall_hold", imem_wdata, 32'h0000_0093);
    imem_ready = 1'b1;
    repeat (6) sample();
    chk("stall_drain", 32'(words_written), 32'd10);

    // Illegal requests are dropped and flagged until clear
    req(1, 9'h003, 1, 0, 0, 0, 0, 32'd0); sample();
    req(1, 9'h004, 1, 2, 0, 1, 0, 32'd0); sample();
    req(0, 9'h0, 0, 0, 0, 0, 0, 32'd0);
    chk("illegal_we", 32'(imem_we), 32'h0);
    chk("illegal_err", 32'(err_illegal), 32'h1);
    clear = 1'b1; sample(); clear = 1'b0;
    sample();
    chk("clear_err", 32'(err_illegal), 32'h0);
    chk("clear_addr", imem_addr, BASE_ADDR);

    // Fill to capacity: the twenty-first word must never be written
    for (int i = 0; i < 40; i++) begin
      req(1, 9'h080, 2, 3, 0, 0, 0, 32'(i));
      sample();
    end
    req(0, 9'h0, 0, 0, 0, 0, 0, 32'd0);
    chk("cap_full", 32'(full), 32'h1);
    chk("cap_ww", 32'(words_written), 32'(MEM_WORDS));
    chk("cap_ready", 32'(in_ready), 32'h0);
    clear = 1'b1; sample(); clear = 1'b0;

    // Randomized traffic with occasional flushes and one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] f;
      if ($urandom_range(0, 9) == 0) f = 9'($urandom);
      else f = 9'(1) << $urandom_range(0, 8);
      req(1'($urandom_range(0, 3) != 0), f, 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 1'($urandom), $urandom);
      imem_ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 49) == 0);
      if (n == 1500) begin
        #1;
        rst = 1'b1;
        #1;
        reset_literals("async_rst");
        sample();
        sample();
        rst = 1'b0;
      end else begin
        sample();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
